// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with operand forwarding, shift/compare ops and
// iterative shift-add multiply / restoring divide behind a valid/ready handshake.
module alu_mc #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] imm,
   input  logic            use_imm,
   input  logic [1:0]      fwd_a,
   input  logic [1:0]      fwd_b,
   input  logic [XLEN-1:0] ex_mem,
   input  logic [XLEN-1:0] mem_wb,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);
   localparam int SH_W = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state;
   logic [XLEN-1:0]   opnd;      // multiplicand (MUL) or divisor magnitude (DIV)
   logic [2*XLEN-1:0] acc;       // {hi, lo}: product accumulator or {remainder, quotient}
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        op_q;
   logic              neg_q, neg_r;

   logic [XLEN-1:0] a, b, a_mag, b_mag, fast_res;
   logic            is_mul, is_div, div_signed, div_rem, div_zero, div_ovf, fast;
   logic            accept;

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      a = rs1;
      case (fwd_a)
         2'd1:    a = ex_mem;
         2'd2:    a = mem_wb;
         default: a = rs1;
      endcase
      b = rs2;
      if (use_imm) b = imm;
      else begin
         case (fwd_b)
            2'd1:    b = ex_mem;
            2'd2:    b = mem_wb;
            default: b = rs2;
         endcase
      end
   end

   assign in_ready   = (state == S_IDLE || (state == S_DONE && out_ready)) && !flush;
   assign accept     = in_valid && in_ready;
   assign is_mul     = (alu_op[3:1] == 3'b101);
   assign is_div     = (alu_op[3:2] == 2'b11);
   assign div_signed = !alu_op[0];
   assign div_rem    = alu_op[1];
   assign div_zero   = (b == '0);
   assign div_ovf    = div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign a_mag      = (div_signed && a[XLEN-1]) ? -a : a;
   assign b_mag      = (div_signed && b[XLEN-1]) ? -b : b;
   assign fast       = !is_mul && !(is_div && !div_zero && !div_ovf);

   always_comb begin
      fast_res = '0;
      case (alu_op)
         4'd0:  fast_res = a + b;
         4'd1:  fast_res = a - b;
         4'd2:  fast_res = a & b;
         4'd3:  fast_res = a | b;
         4'd4:  fast_res = a ^ b;
         4'd5:  fast_res = a << b[SH_W-1:0];
         4'd6:  fast_res = a >> b[SH_W-1:0];
         4'd7:  fast_res = $unsigned($signed(a) >>> b[SH_W-1:0]);
         4'd8:  fast_res = XLEN'($signed(a) < $signed(b));
         4'd9:  fast_res = XLEN'(a < b);
         default: begin
            // Only the divide special cases reach here as fast ops.
            if (div_zero)     fast_res = div_rem ? a : '1;
            else if (div_ovf) fast_res = div_rem ? '0 : a;
         end
      endcase
   end

   // One iteration of each engine.
   logic [XLEN:0]     mul_sum, div_sh;
   logic [XLEN-1:0]   div_sub, mul_out, div_out, quo, rem;
   logic [2*XLEN-1:0] acc_mul_next, acc_div_next;
   logic              div_ge;

   always_comb begin
      mul_sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_mul_next = {mul_sum, acc[XLEN-1:1]};
      mul_out      = op_q[0] ? acc_mul_next[2*XLEN-1:XLEN] : acc_mul_next[XLEN-1:0];

      div_sh       = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_ge       = (div_sh >= {1'b0, opnd});
      div_sub      = div_sh[XLEN-1:0] - opnd;
      acc_div_next = {div_ge ? div_sub : div_sh[XLEN-1:0], acc[XLEN-2:0], div_ge};
      quo          = acc_div_next[XLEN-1:0];
      rem          = acc_div_next[2*XLEN-1:XLEN];
      div_out      = op_q[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
   end

   // NOTE: state is written with non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the datapath registers are reset too; they are few and it keeps simulation X-free.
      if (!rst_n) begin
         state     <= S_IDLE;
         opnd      <= '0;
         acc       <= '0;
         cnt       <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
      end else if (flush) begin
         state     <= S_IDLE;
         cnt       <= '0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         op_q <= alu_op;
         if (fast) begin
            result    <= fast_res;
            zero      <= (fast_res == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
         end else begin
            zero      <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= CNT_W'(XLEN);
            if (is_mul) begin
               opnd  <= a;
               acc   <= {{XLEN{1'b0}}, b};
               state <= S_MUL;
            end else begin
               opnd  <= b_mag;
               acc   <= {{XLEN{1'b0}}, a_mag};
               neg_q <= div_signed && (a[XLEN-1] ^ b[XLEN-1]);
               neg_r <= div_signed && a[XLEN-1];
               state <= S_DIV;
            end
         end
      end else begin
         case (state)
            S_MUL, S_DIV: begin
               acc <= (state == S_MUL) ? acc_mul_next : acc_div_next;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  result    <= (state == S_MUL) ? mul_out : div_out;
                  zero      <= (((state == S_MUL) ? mul_out : div_out) == '0);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  zero      <= 1'b0;
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
